// File: rtl/butterfly_sequencer.sv
// butterfly_sequencer: sequences one radix-2 complex butterfly (y = a + w*b, z = a - w*b) over a register file.
// Optional macro BF_SATURATE_EN: saturate results to DW bits instead of wrapping.
`default_nettype none

module butterfly_sequencer #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cal_flag,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_en,
  output logic          busy,
  output logic          Ready_dis
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MUL   = 3'd2,
    S_SUM   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_cnt;
  logic signed [DW-1:0]   r_op   [6];
  logic signed [2*DW-1:0] r_prod [4];
  logic [DW-1:0]          r_res  [4];
  logic [AW-1:0]          r_rd_addr;
  logic [AW-1:0]          r_wr_addr;
  logic [DW-1:0]          r_wr_data;
  logic                   r_wr_en;
  logic                   r_busy;
  logic                   r_ready;

  // Operand order by address: 0 Rew, 1 Imw, 2 Reb, 3 Imb, 4 Rea, 5 Ima
  logic signed [DW-1:0]   w_ma;
  logic signed [DW-1:0]   w_mb;
  logic signed [2*DW-1:0] w_prod;

  always_comb begin
    w_ma = r_op[0];
    w_mb = r_op[2];
    case (r_cnt[1:0])
      2'd1: begin w_ma = r_op[1]; w_mb = r_op[3]; end
      2'd2: begin w_ma = r_op[0]; w_mb = r_op[3]; end
      2'd3: begin w_ma = r_op[1]; w_mb = r_op[2]; end
      default: ;
    endcase
  end

  assign w_prod = w_ma * w_mb;

  logic signed [2*DW:0] w_re_full;
  logic signed [2*DW:0] w_im_full;
  logic signed [DW+1:0] w_tr;
  logic signed [DW+1:0] w_ti;
  logic signed [DW+1:0] w_rea_x;
  logic signed [DW+1:0] w_ima_x;
  logic signed [DW+1:0] w_sum [4];
  logic [DW-1:0]        w_red [4];

  assign w_re_full = (2*DW+1)'(r_prod[0]) - (2*DW+1)'(r_prod[1]);
  assign w_im_full = (2*DW+1)'(r_prod[2]) + (2*DW+1)'(r_prod[3]);
  // Dropping the low DW-1 bits is the floor (arithmetic) shift by DW-1
  assign w_tr      = w_re_full[2*DW:DW-1];
  assign w_ti      = w_im_full[2*DW:DW-1];
  assign w_rea_x   = (DW+2)'(r_op[4]);
  assign w_ima_x   = (DW+2)'(r_op[5]);
  assign w_sum[0]  = w_rea_x + w_tr;
  assign w_sum[1]  = w_ima_x + w_ti;
  assign w_sum[2]  = w_rea_x - w_tr;
  assign w_sum[3]  = w_ima_x - w_ti;

  logic w_unused;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_reduce
`ifdef BF_SATURATE_EN
      always_comb begin
        if (w_sum[g][DW+1:DW-1] == '0 || w_sum[g][DW+1:DW-1] == '1)
          w_red[g] = w_sum[g][DW-1:0];
        else if (w_sum[g][DW+1])
          w_red[g] = {1'b1, {(DW-1){1'b0}}};
        else
          w_red[g] = {1'b0, {(DW-1){1'b1}}};
      end
`else
      assign w_red[g] = w_sum[g][DW-1:0];
`endif
    end
  endgenerate

`ifdef BF_SATURATE_EN
  assign w_unused = ^{w_re_full[DW-2:0], w_im_full[DW-2:0]};
`else
  assign w_unused = ^{w_re_full[DW-2:0], w_im_full[DW-2:0],
                      w_sum[0][DW+1:DW], w_sum[1][DW+1:DW],
                      w_sum[2][DW+1:DW], w_sum[3][DW+1:DW]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      for (int i = 0; i < 6; i++) r_op[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        r_prod[i] <= '0;
        r_res[i]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cal_flag) begin
            r_state   <= S_LOAD;
            r_cnt     <= '0;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          // Read data lags the address by one cycle
          if (r_cnt != 3'd0) r_op[r_cnt - 3'd1] <= rd_data;
          if (r_cnt == 3'd6) begin
            r_state   <= S_MUL;
            r_cnt     <= '0;
            r_rd_addr <= '0;
          end else begin
            r_cnt     <= r_cnt + 3'd1;
            r_rd_addr <= (r_cnt < 3'd5) ? AW'(r_cnt + 3'd1) : '0;
          end
        end
        S_MUL: begin
          r_prod[r_cnt[1:0]] <= w_prod;
          if (r_cnt == 3'd3) begin
            r_state <= S_SUM;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_SUM: begin
          for (int i = 0; i < 4; i++) r_res[i] <= w_red[i];
          r_state   <= S_WRITE;
          r_cnt     <= '0;
          r_wr_en   <= 1'b1;
          r_wr_addr <= AW'(6);
          r_wr_data <= w_red[0];
        end
        S_WRITE: begin
          if (r_cnt == 3'd3) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt     <= r_cnt + 3'd1;
            r_wr_addr <= r_wr_addr + AW'(1);
            r_wr_data <= r_res[r_cnt[1:0] + 2'd1];
          end
        end
        S_DONE: begin
          if (!cal_flag) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rd_addr   = r_rd_addr;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wr_en     = r_wr_en;
  assign busy      = r_busy;
  assign Ready_dis = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_butterfly_sequencer.sv
// tb_butterfly_sequencer: scoreboard bench for butterfly_sequencer with a register-file model.
`default_nettype none

module tb_butterfly_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cal_flag;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       busy;
  logic       Ready_dis;

  butterfly_sequencer #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .cal_flag(cal_flag),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .Ready_dis(Ready_dis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t              exp_q[$];
  logic [7:0]        mem [16];
  logic signed [7:0] op_v [6];
  int                total = 0;
  int                bad = 0;
  int                wr_count = 0;

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard head
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      exp_t e;
      wr_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got addr=%0d data=%0d want no write", wr_addr, $signed(wr_data));
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%0d want addr=%0d data=%0d",
                   wr_addr, $signed(wr_data), e.a, $signed(e.d));
        end
      end
    end
  end

  function automatic logic [7:0] red(input int v);
`ifdef BF_SATURATE_EN
    if (v > 127) return 8'd127;
    if (v < -128) return 8'h80;
`endif
    return v[7:0];
  endfunction

  task automatic push(input int a, input int d);
    exp_t e;
    e.a = a[3:0];
    e.d = d[7:0];
    exp_q.push_back(e);
  endtask

  // Reference: complex w*b scaled by 2^-7 with floor, added to/subtracted from a
  task automatic push_model();
    int rw, iw, rb, ib, ra, ia, tr, ti;
    rw = op_v[0]; iw = op_v[1]; rb = op_v[2];
    ib = op_v[3]; ra = op_v[4]; ia = op_v[5];
    tr = (rw * rb - iw * ib) >>> 7;
    ti = (rw * ib + iw * rb) >>> 7;
    push(6, red(ra + tr));
    push(7, red(ia + ti));
    push(8, red(ra - tr));
    push(9, red(ia - ti));
  endtask

  task automatic run(input int hold);
    int w0;
    w0 = wr_count;
    for (int i = 0; i < 6; i++) mem[i] = op_v[i];
    @(negedge clk);
    cal_flag = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      chk($sformatf("flags{wr_en,busy,rdy}@cycle%0d", k), {wr_en, busy, Ready_dis},
          (k <= 12) ? 3'b010 : (k <= 16) ? 3'b110 : 3'b001);
    end
    cal_flag = 1'b0;
    @(negedge clk);
    chk("flags_after_release", {wr_en, busy, Ready_dis}, 0);
    chk("writes_per_run", wr_count - w0, 4);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1;
    cal_flag = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {rd_addr, wr_addr, wr_data, wr_en, busy, Ready_dis}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outputs", {rd_addr, wr_addr, wr_data, wr_en, busy, Ready_dis}, 0);

    op_v = '{8'sd64, 8'sd0, 8'sd40, -8'sd20, 8'sd10, 8'sd5};
    push(6, 30); push(7, -5); push(8, -10); push(9, 15);
    run(17);

    op_v = '{8'sd127, 8'sd0, 8'sd127, 8'sd0, 8'sd100, 8'sd0};
`ifdef BF_SATURATE_EN
    push(6, 127);
`else
    push(6, -30);
`endif
    push(7, 0); push(8, -26); push(9, 0);
    run(17);

    op_v = '{8'sd0, 8'sd64, -8'sd1, 8'sd0, 8'sd0, 8'sd0};
    push(6, 0); push(7, -1); push(8, 0); push(9, 1);
    run(17);

    op_v = '{-8'sd128, -8'sd128, -8'sd128, 8'sd127, -8'sd128, 8'sd127};
    push_model();
    run(40);

    // Abort in MUL: asynchronous reset clears outputs and no writes follow
    op_v = '{8'sd50, 8'sd60, 8'sd70, 8'sd80, 8'sd90, 8'sd100};
    for (int i = 0; i < 6; i++) mem[i] = op_v[i];
    w0 = wr_count;
    @(negedge clk);
    cal_flag = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {rd_addr, wr_addr, wr_data, wr_en, busy, Ready_dis}, 0);
    @(negedge clk);
    cal_flag = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("writes_after_abort", wr_count - w0, 0);
    chk("ready_after_abort", Ready_dis, 0);

    op_v = '{8'sd50, 8'sd60, 8'sd70, 8'sd80, 8'sd90, 8'sd100};
    push_model();
    run(17);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 6; i++) op_v[i] = 8'($urandom_range(0, 255));
      push_model();
      run(17 + int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/butterfly_sequencer.md
BUTTERFLY_SEQUENCER -- requirements
Module: butterfly_sequencer

Interface
REQ-001 Parameter DW, default 8: operand/result width; signed two's complement; twiddle format Q1.(DW-1).
REQ-002 Parameter AW, default 4: register-file address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cal_flag  input  1  level request from the input controller to compute one butterfly.
REQ-006 rd_addr  output  AW  register-file read address; rd_data is valid one cycle after rd_addr is presented.
REQ-007 rd_data  input  DW  register-file read data.
REQ-008 wr_addr  output  AW  register-file write address.
REQ-009 wr_data  output  DW  register-file write data.
REQ-010 wr_en  output  1  register-file write strobe; one write per asserted cycle.
REQ-011 busy  output  1  high in LOAD, MUL, SUM and WRITE.
REQ-012 Ready_dis  output  1  results written; held high in DONE.

Function
REQ-013 Fixed address map: Rew=0, Imw=1, Reb=2, Imb=3, Rea=4, Ima=5, Rey=6, Imy=7, Rez=8, Imz=9.
REQ-014 FSM states: IDLE, LOAD, MUL, SUM, WRITE, DONE; all outputs decoded from registered state/counters (Moore).
REQ-015 IDLE: outputs 0; on an edge sampling cal_flag=1, go to LOAD.
REQ-016 LOAD, 7 cycles, step s=0..6: rd_addr=s for s<=5, else 0; at steps 1..6 capture rd_data into operand s-1.
REQ-017 MUL, 4 cycles, one shared DWxDW signed multiplier: Rew*Reb, Imw*Imb, Rew*Imb, Imw*Reb, in that order; products 2*DW bits.
REQ-018 SUM, 1 cycle: tr = (Rew*Reb - Imw*Imb) >>> (DW-1); ti = (Rew*Imb + Imw*Reb) >>> (DW-1); arithmetic shift (floor); intermediate width 2*DW+1.
REQ-019 Results in DW+2 bits: Rey=Rea+tr, Imy=Ima+ti, Rez=Rea-tr, Imz=Ima-ti; reduced to DW bits per REQ-031.
REQ-020 WRITE, 4 cycles: wr_en=1, with (wr_addr, wr_data) = (6,Rey), (7,Imy), (8,Rez), (9,Imz) in order.
REQ-021 Cycle numbering: the edge sampling cal_flag=1 in IDLE ends cycle 0. LOAD occupies cycles 1-7, MUL 8-11, SUM 12, WRITE 13-16, DONE from cycle 17.
REQ-022 DONE: Ready_dis=1, busy=0, wr_en=0. Remain in DONE while cal_flag=1; go to IDLE on the first edge sampling cal_flag=0.
REQ-023 cal_flag changes in LOAD/MUL/SUM/WRITE are ignored; the computation always completes.
REQ-024 cal_flag=1 sampled in IDLE on the edge leaving DONE is not possible; a new run requires cal_flag to be sampled 0 in DONE and then 1 in IDLE.
REQ-025 rd_addr/rd_data never collide with writes: no read is issued in WRITE and no write is issued in LOAD.
REQ-026 Operand and result registers are not cleared between runs; every run reloads all six operands.

Reset
REQ-027 rst=1 forces IDLE immediately and independently of clk.
REQ-028 Reset values: rd_addr=0, wr_addr=0, wr_data=0, wr_en=0, busy=0, Ready_dis=0; counters and operand/result registers=0.
REQ-029 Reset asserted mid-run aborts the run; no further writes occur and no partial Ready_dis is produced.
REQ-030 After rst deasserts, the block waits in IDLE for cal_flag=1.

Configuration
REQ-031 Macro BF_SATURATE_EN: when defined, each DW+2-bit result saturates to [-2^(DW-1), 2^(DW-1)-1]; when undefined, results keep the low DW bits (two's-complement wrap).

Verification (DW=8)
REQ-032 w=(64,0), b=(40,-20), a=(10,5), cal_flag=1 -> writes 6:30, 7:-5, 8:-10, 9:15 in cycles 13-16; Ready_dis high from cycle 17.
REQ-033 w=(127,0), b=(127,0), a=(100,0) -> Rey=127 with BF_SATURATE_EN, -30 without; Imy=0, Rez=-26, Imz=0 in both builds.
REQ-034 w=(0,64), b=(-1,0), a=(0,0) -> Rey=0, Imy=-1, Rez=0, Imz=1 (floor shift).
REQ-035 Hold cal_flag=1 for 40 cycles -> exactly one run, exactly 4 writes, Ready_dis high until cal_flag=0, low on the next cycle.
REQ-036 Pulse rst during cycle 9 (MUL) -> all outputs 0 at once, no writes to addresses 6-9; a new cal_flag=1 then gives a full run with correct results.
